// File: rtl/fmad_arbiter_pkg.sv
// fmad_arbiter_pkg: shared state type and default sizing for the fmad arbiter.
// FP16_FRACW (fraction width) falls back to half precision when not supplied by constants.sv.
`ifndef FP16_FRACW
`define FP16_FRACW 10
`endif
package fmad_arbiter_pkg;
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_CLEAR
    } fmadArbState_t;
    localparam int NREQ_DEF = 4;
    localparam int TIMEOUT_DEF = 64;
    localparam int WIDTH_DEF = `FP16_FRACW + 1;
endpackage

// File: rtl/fmad_arbiter_rr_picker.sv
// rr_picker: rotate-priority encoder, first valid index strictly after i_last (mod NREQ).
module rr_picker #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_valid,
    input  logic [$clog2(NREQ)-1:0] i_last,
    output logic [NREQ-1:0]         o_grant,
    output logic [$clog2(NREQ)-1:0] o_idx
);
    localparam int IDW = $clog2(NREQ);
    always_comb begin
        int p;
        logic found;
        o_grant = '0;
        o_idx = '0;
        found = 1'b0;
        p = 0;
        for (int k = 1; k <= NREQ; k++) begin
            p = (int'(i_last) + k) % NREQ;
            if (!found && i_valid[p]) begin
                found = 1'b1;
                o_grant[p] = 1'b1;
                o_idx = IDW'(p);
            end
        end
    end
endmodule

// File: rtl/fmad_arbiter.sv
// fmad_arbiter: round-robin sequencer sharing one fmad unit among NREQ requesters.
// Define FMAD_ARB_TIMEOUT_EN to add a WAIT watchdog that aborts with o_resp_err.
module fmad_arbiter
    import fmad_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int OUTWIDTH = 2 * WIDTH,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [NREQ-1:0]           i_req_valid,
    input  logic [NREQ*WIDTH-1:0]     i_req_in1,
    input  logic [NREQ*WIDTH-1:0]     i_req_in2,
    input  logic [NREQ*WIDTH-1:0]     i_req_add,
    output logic [NREQ-1:0]           o_req_ready,
    output logic [WIDTH-1:0]          o_fmad_mul_in1,
    output logic [WIDTH-1:0]          o_fmad_mul_in2,
    output logic [WIDTH-1:0]          o_fmad_add_in,
    output logic                      o_fmad_start,
    output logic                      o_fmad_clear,
    input  logic                      i_fmad_done,
    input  logic [OUTWIDTH-1:0]       i_fmad_out,
    output logic                      o_resp_valid,
    output logic [$clog2(NREQ)-1:0]   o_resp_id,
    output logic [OUTWIDTH-1:0]       o_resp_out,
    output logic                      o_resp_err,
    output logic                      o_busy
);
    localparam int IDW = $clog2(NREQ);
    fmadArbState_t r_state, w_next;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0] w_idx, r_gid, r_last;
    logic w_take, w_finish, w_timeout;
    logic r_start, r_clear, r_resp_valid, r_resp_err;
    logic [IDW-1:0] r_resp_id;
    logic [OUTWIDTH-1:0] r_resp_out;
    logic [WIDTH-1:0] r_in1, r_in2, r_add;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .i_valid (i_req_valid),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= ARB_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE:  w_next = |i_req_valid ? ARB_ISSUE : ARB_IDLE;
            ARB_ISSUE: w_next = ARB_WAIT;
            ARB_WAIT:  w_next = (i_fmad_done || w_timeout) ? ARB_CLEAR : ARB_WAIT;
            default:   w_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        w_take = (r_state == ARB_IDLE) && |i_req_valid && !i_reset;
        w_finish = (r_state == ARB_WAIT) && (i_fmad_done || w_timeout);
        o_req_ready = w_take ? w_grant : '0;
        o_busy = r_state != ARB_IDLE;
    end

    // Strobes are registered from the next state so they are glitch-free flop outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_start <= 1'b0;
            r_clear <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err <= 1'b0;
            r_resp_id <= '0;
            r_resp_out <= '0;
            r_in1 <= '0;
            r_in2 <= '0;
            r_add <= '0;
            r_gid <= '0;
            r_last <= IDW'(NREQ - 1);
        end else begin
            r_start <= w_next == ARB_ISSUE;
            r_clear <= w_next == ARB_CLEAR;
            r_resp_valid <= w_next == ARB_CLEAR;
            if (w_take) begin
                r_in1 <= i_req_in1[w_idx*WIDTH +: WIDTH];
                r_in2 <= i_req_in2[w_idx*WIDTH +: WIDTH];
                r_add <= i_req_add[w_idx*WIDTH +: WIDTH];
                r_gid <= w_idx;
                r_last <= w_idx;
            end
            if (w_finish) begin
                r_resp_out <= w_timeout ? '0 : i_fmad_out;
                r_resp_id <= r_gid;
                r_resp_err <= w_timeout;
            end
        end
    end

`ifdef FMAD_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);
    logic [CNTW-1:0] r_cnt;
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_cnt <= '0;
        else r_cnt <= (r_state == ARB_WAIT) ? r_cnt + 1'b1 : '0;
    end
    assign w_timeout = (r_state == ARB_WAIT) && !i_fmad_done && (r_cnt == CNTW'(TIMEOUT));
`else
    assign w_timeout = 1'b0;
`endif

    assign o_fmad_mul_in1 = r_in1;
    assign o_fmad_mul_in2 = r_in2;
    assign o_fmad_add_in = r_add;
    assign o_fmad_start = r_start;
    assign o_fmad_clear = r_clear;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_id = r_resp_id;
    assign o_resp_out = r_resp_out;
    assign o_resp_err = r_resp_err;
endmodule

// File: tb/tb_fmad_arbiter.sv
// tb_fmad_arbiter: directed scoreboard bench for fmad_arbiter with a behavioural fmad unit.
module tb_fmad_arbiter;
    localparam int NREQ = 4;
    localparam int WIDTH = 11;
    localparam int OUTW = 22;
    localparam int IDW = 2;
`ifdef FMAD_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [OUTW-1:0] out;
        logic err;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_in1 = '0, req_in2 = '0, req_add = '0;
    logic [NREQ-1:0] o_req_ready;
    logic [WIDTH-1:0] o_fmad_mul_in1, o_fmad_mul_in2, o_fmad_add_in;
    logic o_fmad_start, o_fmad_clear, o_resp_valid, o_resp_err, o_busy;
    logic [IDW-1:0] o_resp_id;
    logic [OUTW-1:0] o_resp_out;
    logic fmad_done = 1'b0;
    logic [OUTW-1:0] fmad_out = '0;

    resp_t exp_q[$];
    int gnt_q[$];
    int n_vec = 0, n_err = 0;
    int lat = 3;
    bit hang = 1'b0;
    int cnt = 0;
    logic [NREQ-1:0] persist = '0;
    int n_hs = 0;

    always #5 clk = ~clk;

    fmad_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .OUTWIDTH(OUTW), .TIMEOUT(TMO)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_req_valid    (req_valid),
        .i_req_in1      (req_in1),
        .i_req_in2      (req_in2),
        .i_req_add      (req_add),
        .o_req_ready    (o_req_ready),
        .o_fmad_mul_in1 (o_fmad_mul_in1),
        .o_fmad_mul_in2 (o_fmad_mul_in2),
        .o_fmad_add_in  (o_fmad_add_in),
        .o_fmad_start   (o_fmad_start),
        .o_fmad_clear   (o_fmad_clear),
        .i_fmad_done    (fmad_done),
        .i_fmad_out     (fmad_out),
        .o_resp_valid   (o_resp_valid),
        .o_resp_id      (o_resp_id),
        .o_resp_out     (o_resp_out),
        .o_resp_err     (o_resp_err),
        .o_busy         (o_busy)
    );

    // Behavioural fmad: result after lat cycles, done sticky until clear or reset.
    always @(posedge clk or posedge rst) begin
        if (rst || o_fmad_clear) begin
            fmad_done <= 1'b0;
            fmad_out <= '0;
            cnt <= 0;
        end else if (o_fmad_start) cnt <= lat;
        else if (cnt == 1) begin
            cnt <= 0;
            fmad_done <= !hang;
            fmad_out <= OUTW'(o_fmad_mul_in1) * OUTW'(o_fmad_mul_in2) + OUTW'(o_fmad_add_in);
        end else if (cnt > 1) cnt <= cnt - 1;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int g;
        resp_t e;
        if (!rst) begin
            if (|(o_req_ready & req_valid)) begin
                g = -1;
                for (int i = 0; i < NREQ; i++) if (o_req_ready[i]) g = i;
                chk("ready_onehot", longint'($onehot(o_req_ready)), 1);
                if (gnt_q.size() == 0) chk("unexpected_grant", g, -1);
                else chk("grant_id", g, gnt_q.pop_front());
            end
            if (o_resp_valid) begin
                chk("clear_with_resp", o_fmad_clear, 1);
                if (exp_q.size() == 0) chk("unexpected_resp_id", o_resp_id, -1);
                else begin
                    e = exp_q.pop_front();
                    chk("resp_id", o_resp_id, e.id);
                    chk("resp_out", o_resp_out, e.out);
                    chk("resp_err", o_resp_err, e.err);
                end
            end
        end
    end

    task automatic step();
        logic [NREQ-1:0] hs;
        @(negedge clk);
        hs = req_valid & o_req_ready;
        if (|hs) n_hs++;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~(hs & ~persist);
    endtask

    task automatic offer(input int i, input int a, input int b, input int c);
        req_in1[i*WIDTH +: WIDTH] = WIDTH'(a);
        req_in2[i*WIDTH +: WIDTH] = WIDTH'(b);
        req_add[i*WIDTH +: WIDTH] = WIDTH'(c);
        req_valid[i] = 1'b1;
    endtask

    task automatic expect_op(input int g, input int res, input bit err);
        gnt_q.push_back(g);
        exp_q.push_back({IDW'(g), OUTW'(res), err});
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        while ((exp_q.size() != 0 || req_valid != 0 || o_busy) && k < maxc) begin
            step();
            k++;
        end
        if (k >= maxc) chk("drain_timeout", k, 0);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_ctl"}, {o_req_ready, o_fmad_start, o_fmad_clear, o_busy}, 0);
        chk({nm, "_ops"}, {o_fmad_mul_in1, o_fmad_mul_in2, o_fmad_add_in}, 0);
        chk({nm, "_resp"}, {o_resp_valid, o_resp_id, o_resp_out, o_resp_err}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk_reset_outs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n;
        do_reset();
        // Single op with cycle-level checks of grant and start.
        offer(0, 3, 5, 7);
        expect_op(0, 22, 1'b0);
        @(negedge clk);
        chk("t1_ready", o_req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        chk("t1_start", o_fmad_start, 1);
        chk("t1_ops", {o_fmad_mul_in1, o_fmad_mul_in2, o_fmad_add_in}, {11'd3, 11'd5, 11'd7});
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t1_start_pulse", {o_fmad_start, o_busy}, 2'b01);
        @(posedge clk);
        #1;
        drain(100);
        // All four valid after reset: strict rotation from requester 0.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            offer(i, i + 1, 2, i);
            expect_op(i, (i + 1) * 2 + i, 1'b0);
        end
        drain(200);
        // Persistent req1/req3 alternate after req0 is served.
        n_hs = 0;
        offer(0, 3, 5, 7);
        expect_op(0, 22, 1'b0);
        step();
        offer(1, 1, 1, 1);
        offer(3, 2, 3, 4);
        persist = 4'b1010;
        for (int r = 0; r < 2; r++) begin
            expect_op(1, 2, 1'b0);
            expect_op(3, 10, 1'b0);
        end
        k = 0;
        while (n_hs < 5 && k < 200) begin
            step();
            k++;
        end
        chk("t3_handshakes", n_hs, 5);
        persist = '0;
        req_valid = '0;
        drain(100);
        // Full-width operands.
        offer(2, 2047, 2047, 2047);
        expect_op(2, 4192256, 1'b0);
        drain(100);
        // Reset during WAIT abandons the op; requester 0 wins afterwards.
        offer(1, 5, 5, 5);
        gnt_q.push_back(1);
        step();
        step();
        rst = 1'b1;
        #1;
        chk_reset_outs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        offer(0, 1, 2, 3);
        offer(2, 4, 4, 4);
        expect_op(0, 5, 1'b0);
        expect_op(2, 20, 1'b0);
        drain(200);
`ifdef FMAD_ARB_TIMEOUT_EN
        hang = 1'b1;
        offer(3, 1, 1, 1);
        expect_op(3, 0, 1'b1);
        step();
        step();
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (o_resp_valid) break;
            @(posedge clk);
            #1;
            n++;
        end
        chk("timeout_latency", n, 9);
        @(posedge clk);
        #1;
        chk("timeout_idle", o_busy, 0);
        hang = 1'b0;
`endif
        repeat (3) step();
        chk("exp_q_empty", exp_q.size(), 0);
        chk("gnt_q_empty", gnt_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
